// File: rtl/mem_copy_engine.sv
// Word-granular memory-to-memory copy engine.
// Reads one 32-bit word from the source pointer, then writes it to the
// destination pointer. Each word takes two cycles: READ, then WRITE.
// Ports:
//   clock_in, reset       - clock; asynchronous active-low reset
//   start, srcAddr,
//   dstAddr, length       - copy request, sampled only in IDLE
//   abort                 - stop after the current access
//   busy, done, error,
//   aborted, wordsDone    - status (done/error/aborted are one-cycle pulses)
//   address, writeData,
//   memWrite, memRead,
//   readData              - single-port memory interface
module mem_copy_engine #(
  parameter int unsigned MAX_LEN_W = 8
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          srcAddr,
  input  logic [31:0]          dstAddr,
  input  logic [MAX_LEN_W-1:0] length,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 aborted,
  output logic [MAX_LEN_W-1:0] wordsDone,
  output logic [31:0]          address,
  output logic [31:0]          writeData,
  output logic                 memWrite,
  output logic                 memRead,
  input  logic [31:0]          readData
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_src, w_src_nxt;
  logic [ADDR_W-1:0]    r_dst, w_dst_nxt;
  logic [MAX_LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]    r_data, w_data_nxt;
  logic [MAX_LEN_W-1:0] r_words, w_words_nxt;

  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_error, w_error_nxt;
  logic                 r_aborted, w_aborted_nxt;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic [DATA_W-1:0]    r_wdata, w_wdata_nxt;
  logic                 r_mrd, w_mrd_nxt;
  logic                 r_mwr, w_mwr_nxt;

  logic                 w_misaligned;

  assign w_misaligned = (srcAddr[1:0] != 2'b00) || (dstAddr[1:0] != 2'b00);

  // Next-state, datapath and next-output decode. Outputs are computed from
  // the next state so that registering them keeps them aligned with the state.
  always_comb begin
    w_state_nxt   = r_state;
    w_src_nxt     = r_src;
    w_dst_nxt     = r_dst;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_words_nxt   = r_words;
    w_error_nxt   = 1'b0;
    w_aborted_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_misaligned) begin
            w_state_nxt = DONE;
            w_error_nxt = 1'b1;
          end else if (length == '0) begin
            w_words_nxt = '0;
            w_state_nxt = DONE;
          end else begin
            w_src_nxt   = srcAddr;
            w_dst_nxt   = dstAddr;
            w_cnt_nxt   = length;
            w_words_nxt = '0;
            w_state_nxt = READ;
          end
        end
      end
      READ: begin
        w_data_nxt = readData;
        if (abort) begin
          w_state_nxt   = DONE;
          w_aborted_nxt = 1'b1;
        end else begin
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        w_src_nxt   = r_src + ADDR_W'(4);
        w_dst_nxt   = r_dst + ADDR_W'(4);
        w_cnt_nxt   = r_cnt - MAX_LEN_W'(1);
        w_words_nxt = r_words + MAX_LEN_W'(1);
        // Last-word completion takes priority over a coincident abort.
        if (r_cnt == MAX_LEN_W'(1)) begin
          w_state_nxt = DONE;
        end else if (abort) begin
          w_state_nxt   = DONE;
          w_aborted_nxt = 1'b1;
        end else begin
          w_state_nxt = READ;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt  = (w_state_nxt == READ) || (w_state_nxt == WRITE);
    w_done_nxt  = (w_state_nxt == DONE);
    w_mrd_nxt   = (w_state_nxt == READ);
    w_mwr_nxt   = (w_state_nxt == WRITE);
    w_addr_nxt  = '0;
    w_wdata_nxt = '0;
    if (w_state_nxt == READ) begin
      w_addr_nxt = w_src_nxt;
    end else if (w_state_nxt == WRITE) begin
      w_addr_nxt  = w_dst_nxt;
      w_wdata_nxt = w_data_nxt;
    end
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_words   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_aborted <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mrd     <= 1'b0;
      r_mwr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_src     <= w_src_nxt;
      r_dst     <= w_dst_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data    <= w_data_nxt;
      r_words   <= w_words_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_aborted <= w_aborted_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_mrd     <= w_mrd_nxt;
      r_mwr     <= w_mwr_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign aborted   = r_aborted;
  assign wordsDone = r_words;
  assign address   = r_addr;
  assign writeData = r_wdata;
  assign memRead   = r_mrd;
  assign memWrite  = r_mwr;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: behavioural memory plus an access scoreboard.
module tb_mem_copy_engine;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] srcAddr;
  logic [31:0] dstAddr;
  logic [7:0]  length;
  logic        abort;
  logic        busy, done, error, aborted;
  logic [7:0]  wordsDone;
  logic [31:0] address, writeData, readData;
  logic        memWrite, memRead;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  acc_t exp_q[$];

  // Source memory is a fixed pattern; written words live in a shadow array.
  logic [31:0] wmem [1024];
  bit          wv   [1024];

  mem_copy_engine #(.MAX_LEN_W(8)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .start    (start),
    .srcAddr  (srcAddr),
    .dstAddr  (dstAddr),
    .length   (length),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .aborted  (aborted),
    .wordsDone(wordsDone),
    .address  (address),
    .writeData(writeData),
    .memWrite (memWrite),
    .memRead  (memRead),
    .readData (readData)
  );

  always #5 clock_in = ~clock_in;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hDA7A_0000 + a;
  endfunction

  function automatic logic [9:0] idx(input logic [31:0] a);
    return a[11:2];
  endfunction

  assign readData = wv[idx(address)] ? wmem[idx(address)] : pat(address);

  // Memory commits writes on the falling edge.
  always @(negedge clock_in) begin
    if (memWrite) begin
      wmem[idx(address)] <= writeData;
      wv[idx(address)]   <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every memory strobe must match the next expected access.
  always @(negedge clock_in) begin
    if (memRead || memWrite) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_access", {memRead, memWrite, address}, 0);
      end else begin
        acc_t e;
        e = exp_q.pop_front();
        chk("acc_write", memWrite, e.wr);
        chk("acc_read", memRead, !e.wr);
        chk("acc_addr", address, e.addr);
        if (e.wr) chk("acc_data", writeData, e.data);
      end
    end
  end

  task automatic push_acc(input logic [31:0] s, input logic [31:0] d, input int k,
                          input bit extra_rd);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back('{1'b0, s + 32'(4 * i), 32'h0});
      exp_q.push_back('{1'b1, d + 32'(4 * i), pat(s + 32'(4 * i))});
    end
    if (extra_rd) exp_q.push_back('{1'b0, s + 32'(4 * k), 32'h0});
  endtask

  task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [7:0] n, input int abort_cyc, input int exp_cyc,
                          input bit exp_err, input bit exp_abt, input logic [7:0] exp_wd);
    int cyc;
    bit seen;
    @(negedge clock_in);
    srcAddr = s;
    dstAddr = d;
    length  = n;
    start   = 1'b1;
    @(posedge clock_in);
    #1 start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clock_in);
      cyc++;
      abort = (cyc == abort_cyc);
      if (cyc == 1 && exp_cyc > 1) chk({tag, "_busy"}, busy, 1);
      if (done) begin
        seen = 1'b1;
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_aborted"}, aborted, exp_abt);
        chk({tag, "_wordsDone"}, wordsDone, exp_wd);
        chk({tag, "_busy_in_done"}, busy, 0);
      end
    end
    abort = 1'b0;
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    @(negedge clock_in);
    chk({tag, "_pulse_end"}, {done, error, aborted}, 0);
    chk({tag, "_acc_left"}, exp_q.size(), 0);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    srcAddr = '0;
    dstAddr = '0;
    length  = '0;
    #3;
    chk("rst_outputs", {busy, done, error, aborted, memRead, memWrite, wordsDone,
                        address, writeData}, 0);
    @(negedge clock_in);
    reset = 1'b1;

    // Basic 3-word copy.
    push_acc(32'h0, 32'h40, 3, 1'b0);
    run_copy("copy3", 32'h0, 32'h40, 8'd3, 0, 7, 1'b0, 1'b0, 8'd3);
    chk("copy3_m40", wmem[idx(32'h40)], pat(32'h0));
    chk("copy3_m44", wmem[idx(32'h44)], pat(32'h4));
    chk("copy3_m48", wmem[idx(32'h48)], pat(32'h8));

    // Misaligned source: error, no access, wordsDone kept.
    run_copy("misalign", 32'h2, 32'h80, 8'd4, 0, 1, 1'b1, 1'b0, 8'd3);

    // Zero length.
    run_copy("len0", 32'h10, 32'h50, 8'd0, 0, 1, 1'b0, 1'b0, 8'd0);

    // Pointer wrap.
    push_acc(32'hFFFF_FFFC, 32'h100, 2, 1'b0);
    run_copy("wrap", 32'hFFFF_FFFC, 32'h100, 8'd2, 0, 5, 1'b0, 1'b0, 8'd2);

    // Abort in the second WRITE: two words land.
    push_acc(32'h200, 32'h300, 2, 1'b0);
    run_copy("abort_wr", 32'h200, 32'h300, 8'd4, 4, 5, 1'b0, 1'b1, 8'd2);
    chk("abort_wr_no3rd", wv[idx(32'h308)], 0);

    // Abort in the second READ: one word lands.
    push_acc(32'h200, 32'h3C0, 1, 1'b1);
    run_copy("abort_rd", 32'h200, 32'h3C0, 8'd3, 3, 4, 1'b0, 1'b1, 8'd1);

    // Abort coinciding with the last write reports normal completion.
    push_acc(32'h20, 32'h380, 1, 1'b0);
    run_copy("abort_last", 32'h20, 32'h380, 8'd1, 2, 3, 1'b0, 1'b0, 8'd1);

    // Reset during the second READ of a 5-word copy.
    push_acc(32'h80, 32'hC0, 1, 1'b1);
    @(negedge clock_in);
    srcAddr = 32'h80;
    dstAddr = 32'hC0;
    length  = 8'd5;
    start   = 1'b1;
    @(posedge clock_in);
    #1 start = 1'b0;
    repeat (3) @(negedge clock_in);
    #2 reset = 1'b0;
    #1;
    chk("midrst_outputs", {busy, done, error, aborted, memRead, memWrite, wordsDone,
                           address, writeData}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_in);
      chk("midrst_no_done", {done, memWrite, memRead}, 0);
    end
    chk("midrst_acc_left", exp_q.size(), 0);
    chk("midrst_w0_kept", wmem[idx(32'hC0)], pat(32'h80));
    chk("midrst_w1_absent", wv[idx(32'hC4)], 0);
    reset = 1'b1;

    push_acc(32'h80, 32'h140, 2, 1'b0);
    run_copy("post_rst", 32'h80, 32'h140, 8'd2, 0, 5, 1'b0, 1'b0, 8'd2);
    chk("post_rst_m144", wmem[idx(32'h144)], pat(32'h84));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
